// File: rtl/reg_status_ckpt_if.sv
// reg_status_ckpt_if: rename/commit/checkpoint bus of the register status table.
//   rename:     renWe, renReg, renROB
//   lookup:     rs1, rs2 -> busy1, rob1, busy2, rob2
//   commit:     validCommit, regCommit, commitROB
//   checkpoint: ckptReq -> ckptGrant, ckptTag, ckptFull; ckptFree, restore, restoreTag, flushAll
interface reg_status_ckpt_if #(parameter int REG = 4, parameter int ROB = 2, parameter int CKPTW = 1);
    logic           renWe;
    logic [REG:0]   renReg;
    logic [ROB:0]   renROB;
    logic [REG:0]   rs1;
    logic [REG:0]   rs2;
    logic           busy1;
    logic           busy2;
    logic [ROB:0]   rob1;
    logic [ROB:0]   rob2;
    logic           validCommit;
    logic [REG:0]   regCommit;
    logic [ROB:0]   commitROB;
    logic           ckptReq;
    logic           ckptGrant;
    logic [CKPTW:0] ckptTag;
    logic           ckptFull;
    logic           ckptFree;
    logic           restore;
    logic [CKPTW:0] restoreTag;
    logic           flushAll;
    modport master (
        output renWe, renReg, renROB, rs1, rs2, validCommit, regCommit, commitROB,
               ckptReq, ckptFree, restore, restoreTag, flushAll,
        input  busy1, busy2, rob1, rob2, ckptGrant, ckptTag, ckptFull
    );
    modport slave (
        input  renWe, renReg, renROB, rs1, rs2, validCommit, regCommit, commitROB,
               ckptReq, ckptFree, restore, restoreTag, flushAll,
        output busy1, busy2, rob1, rob2, ckptGrant, ckptTag, ckptFull
    );
endinterface

// File: rtl/reg_status_ckpt.sv
// reg_status_ckpt: register status table with bypassed lookups and circular branch checkpoints.
//   clk          clock
//   globalResetN asynchronous active-low reset
//   bus          reg_status_ckpt_if.slave (rename, lookup, commit, checkpoint/restore/flush)
module reg_status_ckpt #(
    parameter int REG   = 4,
    parameter int ROB   = 2,
    parameter int NCKPT = 4,
    parameter int CKPTW = 1
) (
    input logic             clk,
    input logic             globalResetN,
    reg_status_ckpt_if.slave bus
);
    localparam int N = 2 ** (REG + 1);
    logic [N-1:0]     busy, busy_d, nbusy, rbusy;
    logic [ROB:0]     tag [N];
    logic [ROB:0]     tag_d [N];
    logic [ROB:0]     nt [N];
    logic [N-1:0]     ckBusy [NCKPT];
    logic [N-1:0]     ckBusy_d [NCKPT];
    logic [ROB:0]     ckTag [NCKPT][N];
    logic [ROB:0]     ckTag_d [NCKPT][N];
    logic [CKPTW:0]   head, tail, head_d, tail_d, rdist;
    logic [CKPTW+1:0] count, count_d;
    logic             ren, cm, freeOk, grant, byp1, byp2;
    always_comb begin
        ren    = bus.renWe & (|bus.renReg) & ~bus.restore & ~bus.flushAll;
        cm     = bus.validCommit & busy[bus.regCommit] & (tag[bus.regCommit] == bus.commitROB);
        freeOk = bus.ckptFree & (count != '0);
        grant  = bus.ckptReq & (count != (CKPTW+2)'(NCKPT)) & ~bus.restore & ~bus.flushAll;
        rdist  = bus.restoreTag - head;
        for (int i = 0; i < N; i++) begin
            nbusy[i] = (ren && bus.renReg == (REG+1)'(i)) | (busy[i] & ~(cm && bus.regCommit == (REG+1)'(i)));
            nt[i]    = (ren && bus.renReg == (REG+1)'(i)) ? bus.renROB : tag[i];
            // restored entries still see this cycle's commit, matched against the slot's own tag
            rbusy[i] = ckBusy[bus.restoreTag][i] & ~(bus.validCommit && bus.regCommit == (REG+1)'(i)
                       && ckTag[bus.restoreTag][i] == bus.commitROB);
            busy_d[i] = bus.flushAll ? 1'b0 : bus.restore ? rbusy[i] : nbusy[i];
            tag_d[i]  = bus.restore ? ckTag[bus.restoreTag][i] : nt[i];
        end
        for (int k = 0; k < NCKPT; k++) begin
            ckBusy_d[k] = ckBusy[k];
            ckTag_d[k]  = ckTag[k];
            if (bus.validCommit && ckBusy[k][bus.regCommit] && ckTag[k][bus.regCommit] == bus.commitROB)
                ckBusy_d[k][bus.regCommit] = 1'b0;
            if (grant && tail == (CKPTW+1)'(k)) begin
                ckBusy_d[k] = nbusy;
                ckTag_d[k]  = nt;
            end
            if (bus.flushAll)
                ckBusy_d[k] = '0;
        end
        head_d  = bus.flushAll ? '0 : head + (CKPTW+1)'(freeOk);
        tail_d  = bus.flushAll ? '0 : bus.restore ? bus.restoreTag : tail + (CKPTW+1)'(grant);
        count_d = bus.flushAll ? '0 : bus.restore ? {1'b0, rdist} - (CKPTW+2)'(freeOk)
                : count + (CKPTW+2)'(grant) - (CKPTW+2)'(freeOk);
        byp1 = ren && bus.rs1 == bus.renReg;
        byp2 = ren && bus.rs2 == bus.renReg;
    end
    assign bus.busy1     = byp1 | (busy[bus.rs1] & ~(cm && bus.rs1 == bus.regCommit));
    assign bus.busy2     = byp2 | (busy[bus.rs2] & ~(cm && bus.rs2 == bus.regCommit));
    assign bus.rob1      = byp1 ? bus.renROB : tag[bus.rs1];
    assign bus.rob2      = byp2 ? bus.renROB : tag[bus.rs2];
    assign bus.ckptGrant = grant;
    assign bus.ckptTag   = tail;
    assign bus.ckptFull  = count == (CKPTW+2)'(NCKPT);
    always_ff @(posedge clk or negedge globalResetN) begin
        if (!globalResetN) begin
            busy  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < N; i++) tag[i] <= '0;
            for (int k = 0; k < NCKPT; k++) begin
                ckBusy[k] <= '0;
                for (int i = 0; i < N; i++) ckTag[k][i] <= '0;
            end
        end else begin
            busy  <= busy_d;
            head  <= head_d;
            tail  <= tail_d;
            count <= count_d;
            for (int i = 0; i < N; i++) tag[i] <= tag_d[i];
            for (int k = 0; k < NCKPT; k++) begin
                ckBusy[k] <= ckBusy_d[k];
                for (int i = 0; i < N; i++) ckTag[k][i] <= ckTag_d[k][i];
            end
        end
    end
endmodule

// File: tb/tb_reg_status_ckpt.sv
// tb_reg_status_ckpt: directed checks of rename/commit bypass, checkpoint, restore, flush and reset.
module tb_reg_status_ckpt;
    logic clk = 1'b0;
    logic globalResetN;
    int   errs = 0;
    int   checks = 0;
    reg_status_ckpt_if b ();
    reg_status_ckpt dut (.clk(clk), .globalResetN(globalResetN), .bus(b));
    always #5 clk = ~clk;
    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", t, got, exp);
        end
    endtask
    task automatic idle();
        b.renWe = 0; b.renReg = 0; b.renROB = 0; b.rs1 = 0; b.rs2 = 0;
        b.validCommit = 0; b.regCommit = 0; b.commitROB = 0;
        b.ckptReq = 0; b.ckptFree = 0; b.restore = 0; b.restoreTag = 0; b.flushAll = 0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask
    always @(posedge clk) begin
        logic [1:0] rd;
        rd = b.restoreTag - dut.head;
        if (globalResetN && b.restore && !b.flushAll)
            assert ({1'b0, rd} < dut.count && !(b.restoreTag == dut.head && b.ckptFree))
            else $error("illegal restore of slot %0d", b.restoreTag);
    end
    initial begin
        idle();
        globalResetN = 0;
        b.rs1 = 5;
        #1;
        check("rst_busy1", b.busy1, 0);
        check("rst_rob1", b.rob1, 0);
        check("rst_full", b.ckptFull, 0);
        check("rst_grant", b.ckptGrant, 0);
        check("rst_tag", b.ckptTag, 0);
        @(negedge clk) globalResetN = 1;
        tick();
        b.renWe = 1; b.renReg = 5; b.renROB = 3; b.rs1 = 5; #1;
        check("ren_byp_busy", b.busy1, 1);
        check("ren_byp_rob", b.rob1, 3);
        tick();
        b.rs1 = 5; #1;
        check("tbl_busy", b.busy1, 1);
        check("tbl_rob", b.rob1, 3);
        b.validCommit = 1; b.regCommit = 5; b.commitROB = 3; #1;
        check("cm_byp", b.busy1, 0);
        tick();
        b.rs1 = 5; #1;
        check("cm_tbl", b.busy1, 0);
        b.renWe = 1; b.renReg = 7; b.renROB = 2;
        b.validCommit = 1; b.regCommit = 7; b.commitROB = 1; b.rs2 = 7; #1;
        check("rc_byp_busy", b.busy2, 1);
        check("rc_byp_rob", b.rob2, 2);
        tick();
        b.rs2 = 7; #1;
        check("rc_tbl_busy", b.busy2, 1);
        check("rc_tbl_rob", b.rob2, 2);
        b.renWe = 1; b.renReg = 0; b.renROB = 5; b.rs1 = 0; #1;
        check("x0_byp_busy", b.busy1, 0);
        check("x0_byp_rob", b.rob1, 0);
        tick();
        b.rs1 = 0; #1;
        check("x0_tbl", b.busy1, 0);
        for (int i = 0; i < 4; i++) begin
            b.ckptReq = 1; b.renWe = 1; b.renReg = 5'(10 + i); b.renROB = 3'(i); #1;
            check("ck_grant", b.ckptGrant, 1);
            check("ck_tag", b.ckptTag, i);
            tick();
        end
        b.ckptReq = 1; #1;
        check("full", b.ckptFull, 1);
        check("full_nogrant", b.ckptGrant, 0);
        tick();
        b.ckptReq = 1; b.ckptFree = 1; #1;
        check("full_free_nogrant", b.ckptGrant, 0);
        tick();
        #1;
        check("free_count", dut.count, 3);
        check("free_notfull", b.ckptFull, 0);
        b.ckptReq = 1; #1;
        check("wrap_grant", b.ckptGrant, 1);
        check("wrap_tag", b.ckptTag, 0);
        tick();
        #1;
        check("refull", b.ckptFull, 1);
        b.flushAll = 1;
        tick();
        b.rs1 = 10; b.rs2 = 13; #1;
        check("fl_busy1", b.busy1, 0);
        check("fl_busy2", b.busy2, 0);
        check("fl_count", dut.count, 0);
        check("fl_tag", b.ckptTag, 0);
        b.ckptReq = 1; #1;
        check("r_tag0", b.ckptTag, 0);
        tick();
        b.ckptReq = 1; b.renWe = 1; b.renReg = 9; b.renROB = 4; #1;
        check("r_tag1", b.ckptTag, 1);
        tick();
        b.renWe = 1; b.renReg = 12; b.renROB = 5;
        tick();
        b.restore = 1; b.restoreTag = 1;
        b.validCommit = 1; b.regCommit = 9; b.commitROB = 4; b.rs1 = 9; b.rs2 = 12; #1;
        check("rs_pre_x9", b.busy1, 0);
        check("rs_pre_x12", b.busy2, 1);
        check("rs_pre_rob12", b.rob2, 5);
        tick();
        b.rs1 = 9; b.rs2 = 12; #1;
        check("rs_x9", b.busy1, 0);
        check("rs_x12", b.busy2, 0);
        check("rs_count", dut.count, 1);
        b.ckptReq = 1; #1;
        check("rs_grant", b.ckptGrant, 1);
        check("rs_tag", b.ckptTag, 1);
        tick();
        b.ckptReq = 1; #1;
        check("rf_tag2", b.ckptTag, 2);
        tick();
        b.ckptFree = 1;
        tick();
        #1;
        check("rf_head1", dut.head, 1);
        check("rf_count2", dut.count, 2);
        b.restore = 1; b.restoreTag = 2; b.ckptFree = 1; b.renWe = 1; b.renReg = 13; b.renROB = 6;
        tick();
        b.rs1 = 13; #1;
        check("rf_ren_ign", b.busy1, 0);
        check("rf_head", dut.head, 2);
        check("rf_count", dut.count, 0);
        check("rf_full", b.ckptFull, 0);
        check("rf_tail", b.ckptTag, 2);
        b.ckptFree = 1;
        tick();
        #1;
        check("free0_count", dut.count, 0);
        check("free0_head", dut.head, 2);
        b.renWe = 1; b.renReg = 3; b.renROB = 1;
        tick();
        b.flushAll = 1; b.ckptReq = 1; b.renWe = 1; b.renReg = 4; b.renROB = 2; #1;
        check("fl_nogrant", b.ckptGrant, 0);
        tick();
        b.rs1 = 3; b.rs2 = 4; #1;
        check("fl2_x3", b.busy1, 0);
        check("fl2_x4", b.busy2, 0);
        check("fl2_count", dut.count, 0);
        check("fl2_tag", b.ckptTag, 0);
        b.renWe = 1; b.renReg = 6; b.renROB = 7; b.ckptReq = 1;
        tick();
        b.rs1 = 6; #1;
        check("pre_rst_busy", b.busy1, 1);
        check("pre_rst_rob", b.rob1, 7);
        check("pre_rst_count", dut.count, 1);
        globalResetN = 0; #1;
        check("mid_rst_busy", b.busy1, 0);
        check("mid_rst_rob", b.rob1, 0);
        check("mid_rst_count", dut.count, 0);
        check("mid_rst_tag", b.ckptTag, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/reg_status_ckpt.md
# reg_status_ckpt

Parametrised register status table with multi-slot branch checkpointing. Per architectural register it holds {busy, ROB tag} of the youngest in-flight writer, answers two source lookups per cycle with same-cycle rename/commit bypass, and keeps a circular buffer of up to NCKPT snapshots so a mispredicted branch restores rename state in one cycle. It sits between decode/rename and the ROB commit stage.

## Interface
- REG, 4: register index width minus one (2^(REG+1) registers)
- ROB, 2: ROB tag width minus one
- NCKPT, 4: checkpoint slots, power of two, ≥2
- CKPTW, 1: checkpoint index width minus one (log2(NCKPT)-1)

- clk  in  1  clock, all state updates on posedge
- globalResetN  in  1  asynchronous, active-low reset
- renWe  in  1  renaming instruction writes renReg
- renReg  in  REG+1  destination register being renamed
- renROB  in  ROB+1  ROB tag of renaming instruction
- rs1, rs2  in  REG+1  source registers of the instruction behind the renaming one
- busy1, busy2  out  1  source pending
- rob1, rob2  out  ROB+1  tag producing the source (valid only when busy)
- validCommit  in  1  an instruction commits this cycle
- regCommit  in  REG+1  its destination register
- commitROB  in  ROB+1  its ROB tag
- ckptReq  in  1  branch in rename requests a snapshot
- ckptGrant  out  1  snapshot taken this cycle
- ckptTag  out  CKPTW+1  slot index given to the branch (= tail pointer)
- ckptFull  out  1  all NCKPT slots live
- ckptFree  in  1  oldest live checkpoint's branch retired; release head slot
- restore  in  1  mispredict: restore slot restoreTag
- restoreTag  in  CKPTW+1  slot to restore
- flushAll  in  1  commit-time flush: clear everything

## Operation
- State: flop arrays busy[], tag[] (2^(REG+1) entries); per slot ckBusy[][], ckTag[][]; head, tail (CKPTW+1 bits, wrap mod NCKPT); count (0..NCKPT).
- Register 0 never busy; renames to x0 ignored; lookups of x0 return busy=0, rob=0.
- Commit match: validCommit & busy[regCommit] & tag[regCommit]==commitROB clears busy[regCommit].
- Rename: renWe & renReg≠0 sets busy[renReg]=1, tag[renReg]=renROB. Rename beats commit clear on the same register.
- Lookup (combinational), priority: rename bypass (rsN==renReg, renWe, ≠0 → busy=1, rob=renROB) > commit match on rsN (busy=0) > table.
- Commit clear also applies to every live slot k where ckBusy[k][regCommit] & ckTag[k][regCommit]==commitROB.
- Snapshot: ckptGrant = ckptReq & ~ckptFull & ~restore & ~flushAll. Slot tail captures the table's next state (this cycle's rename and commit included); tail++, count++.
- ckptFree with count==0 ignored; else head++, count--.
- Restore: table ← slot restoreTag with same-cycle commit clear applied; rename and ckptReq ignored; tail←restoreTag; count←(restoreTag−head) mod NCKPT, minus 1 if ckptFree also asserted (head advances). Restoring a non-live slot, or restoreTag==head with ckptFree, is illegal (bench assertion).
- Priority: flushAll > restore > normal. flushAll clears all busy, head=tail=count=0.

## Timing
- Reset (async, globalResetN=0): busy[], tag[], all slots, head, tail, count = 0; ckptFull=0, ckptGrant=0, ckptTag=0, busy1/2=0, rob1/2=0.
- Lookups and ckptGrant/ckptTag: zero-cycle combinational.
- Table, slot, pointer updates: visible the cycle after the posedge.
- Restore/flush: lookups in that cycle show pre-restore state; restored state visible the next cycle.
- Full: count==NCKPT → ckptFull=1, no grant; same-cycle ckptFree does not enable a grant (ckptFull is registered-state based).
- Wrap: tail/head roll from NCKPT−1 to 0.
- Reset mid-operation discards all state immediately.

## Test plan
- Reset, rename x5→ROB 3, next cycle rs1=5 → busy1=1, rob1=3; commit (5,3) → busy1=0 same cycle, table clear next cycle.
- Rename x7→ROB 2 and commit (7, tag 1) same cycle → x7 stays busy, rob=2; rs2=7 in that cycle → busy2=1, rob2=2.
- Four ckptReq with renames between → tags 0,1,2,3, ckptFull=1; fifth ckptReq → ckptGrant=0; ckptFree → next cycle count=3, next grant tag 0 (wrap).
- Checkpoint 1 taken with x9 busy ROB 4; commit (9,4); restore 1 → x9 not busy; tail=1, later ckptReq gets tag 1.
- Restore tag 2 with head=1 and ckptFree → head=2, count=0, ckptFull=0; rename in that cycle has no effect.
- flushAll during ckptReq and rename x3 → next cycle all busy=0, count=0, no grant; globalResetN pulsed low mid-stream → all outputs 0 immediately.
